tpu_tile_scheduler: RTL
=======================

// Module: tpu_tile_scheduler
// PURPOSE
//  Sequences a 4x4 output-stationary systolic array for C[MxN] = A[MxK] * B[KxN].
//  Walks output tiles (mt outer, nt inner), issues A/B global-buffer reads,
//  clears and feeds the array, waits for drain, then writes four C rows per tile.
//  Sits between the CFU command decoder (in_valid, M/K/N) and the A/B/C buffers.
// PARAMETERS
//  ADDR_BITS  16  width of A/B/C buffer indices
//  ACC_BITS   32  width of one array accumulator; C row = 4*ACC_BITS
//  DRAIN_CYC  8   cycles after the last feed until sa_result is stable (skew + pipeline)
// PORTS
//  clk          in   1             single clock; all state on posedge
//  reset        in   1             synchronous, active-high
//  in_valid     in   1             start pulse; M/K/N sampled same cycle
//  M, K, N      in   8 each        matrix dimensions
//  busy         out  1             high from cycle after accepted start until done
//  A_wr_en      out  1             tied 0 after reset (scheduler only reads)
//  A_index      out  ADDR_BITS     A buffer read address
//  B_wr_en      out  1             tied 0 after reset
//  B_index      out  ADDR_BITS     B buffer read address
//  sa_rst       out  1             clears array accumulators
//  feed_valid   out  1             A/B buffer data is a valid k-slice this cycle
//  sa_result    in   16*ACC_BITS   row r col c at [(r*4+c)*ACC_BITS +: ACC_BITS]
//  C_wr_en      out  1             C buffer write strobe
//  C_index      out  ADDR_BITS     C buffer write address
//  C_data_in    out  4*ACC_BITS    C row; col c at [(3-c)*ACC_BITS +: ACC_BITS]
// BEHAVIOUR
//  Reset: state IDLE; every output 0; tile counters 0. Reset mid-operation aborts at once;
//   no further C writes, busy 0 on the next edge.
//  Layout: MT=ceil(M/4), NT=ceil(N/4). A word addr = mt*K+k. B word addr = nt*K+k.
//   C row addr = nt*M + mt*4 + r. Host pre-pads A/B with zeros; math modulo 2^ADDR_BITS.
//  Start: in_valid in IDLE latches M/K/N; in_valid while busy is ignored (no re-latch).
//   If M, K or N is 0: busy high for exactly one cycle, no reads, no writes.
//  FSM per tile: CLR -> FEED -> DRAIN -> WRITE.
//   CLR   1 cycle: sa_rst=1.
//   FEED  K cycles: A_index/B_index for k=0..K-1, one per cycle.
//   Buffers have 1-cycle read latency: feed_valid = FEED-active delayed 1 cycle
//    (high K cycles, last one in the first DRAIN cycle).
//   DRAIN 1+DRAIN_CYC cycles; no reads.
//   WRITE 4 cycles r=0..3: C_index/C_data_in from sa_result row r; C_wr_en=1 only if
//    mt*4+r < M (padding rows skipped, cycle still spent).
//   After WRITE r=3: nt+1; on nt wrap nt=0, mt+1; after final tile -> IDLE.
//  Tile latency: K+DRAIN_CYC+6 cycles. busy high MT*NT*(K+DRAIN_CYC+6) cycles total,
//   falls the edge after the last WRITE cycle.
//  A_wr_en/B_wr_en never assert. Indices hold last value when not issuing.
// TESTING
//  M=K=N=4: A_index,B_index 0..3; C_wr_en at C_index 0..3; busy high 18 cycles.
//  M=8,K=2,N=4: A_index 0,1 then 2,3; B_index 0,1 twice; C_index 0..3 then 4..7.
//  M=6,K=3,N=8: mt=1 rows 2,3 not written; nt=1 C_index base 6 (rows 6..9 written).
//  K=0 (M=N=4): busy exactly 1 cycle, no C_wr_en, no feed_valid.
//  reset asserted during FEED of 2nd tile: outputs 0 next edge; no C writes after.
//  in_valid re-pulsed mid-run with M=1: ignored; original run completes unchanged.

Source files
------------

// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for a 4x4 output-stationary systolic array: walks output tiles,
// issues A/B buffer reads, clears/feeds/drains the array and writes C rows back.
module tpu_tile_scheduler #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned ACC_BITS  = 32,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               M,
  input  logic [7:0]               K,
  input  logic [7:0]               N,
  output logic                     busy,
  output logic                     A_wr_en,
  output logic [ADDR_BITS-1:0]     A_index,
  output logic                     B_wr_en,
  output logic [ADDR_BITS-1:0]     B_index,
  output logic                     sa_rst,
  output logic                     feed_valid,
  input  logic [16*ACC_BITS-1:0]   sa_result,
  output logic                     C_wr_en,
  output logic [ADDR_BITS-1:0]     C_index,
  output logic [4*ACC_BITS-1:0]    C_data_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_NULL, S_CLR, S_FEED, S_DRAIN, S_WRITE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] m_q, k_q, n_q, m_d, k_d, n_d;
  logic [7:0] mt_q, nt_q, cnt_q, mt_d, nt_d, cnt_d;
  logic       last_mt, last_nt, row_ok;

  logic                   busy_d, sa_rst_d, feed_valid_d, c_wr_en_d;
  logic [ADDR_BITS-1:0]   a_index_d, b_index_d, c_index_d;
  logic [4*ACC_BITS-1:0]  c_data_d;

  // The scheduler only ever reads the operand buffers.
  assign A_wr_en = 1'b0;
  assign B_wr_en = 1'b0;

  assign last_mt = ({1'b0, mt_q} + 9'd1) == ((9'(m_q) + 9'd3) >> 2);
  assign last_nt = ({1'b0, nt_q} + 9'd1) == ((9'(n_q) + 9'd3) >> 2);

  // Next-state, tile counters and next-cycle output values.
  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    k_d          = k_q;
    n_d          = n_q;
    mt_d         = mt_q;
    nt_d         = nt_q;
    cnt_d        = cnt_q;
    busy_d       = 1'b0;
    sa_rst_d     = 1'b0;
    feed_valid_d = 1'b0;
    c_wr_en_d    = 1'b0;
    row_ok       = 1'b0;
    a_index_d    = A_index;
    b_index_d    = B_index;
    c_index_d    = C_index;
    c_data_d     = C_data_in;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d   = M;
          k_d   = K;
          n_d   = N;
          mt_d  = 8'd0;
          nt_d  = 8'd0;
          cnt_d = 8'd0;
          state_d = (M == 8'd0 || K == 8'd0 || N == 8'd0) ? S_NULL : S_CLR;
        end
      end
      S_NULL: state_d = S_IDLE;
      S_CLR: begin
        state_d = S_FEED;
        cnt_d   = 8'd0;
      end
      S_FEED: begin
        if (cnt_q == k_q - 8'd1) begin
          state_d = S_DRAIN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 8'(DRAIN_CYC)) begin
          state_d = S_WRITE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 8'd3) begin
          cnt_d   = 8'd0;
          state_d = S_CLR;
          if (last_nt) begin
            nt_d = 8'd0;
            if (last_mt) state_d = S_IDLE;
            else         mt_d    = mt_q + 8'd1;
          end else begin
            nt_d = nt_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    sa_rst_d     = (state_d == S_CLR);
    // Buffer data arrives one cycle after its address was presented.
    feed_valid_d = (state_q == S_FEED);

    if (state_d == S_FEED) begin
      a_index_d = ADDR_BITS'(mt_d) * ADDR_BITS'(k_q) + ADDR_BITS'(cnt_d);
      b_index_d = ADDR_BITS'(nt_d) * ADDR_BITS'(k_q) + ADDR_BITS'(cnt_d);
    end

    if (state_d == S_WRITE) begin
      row_ok    = (10'({mt_d, 2'b00}) + 10'(cnt_d[1:0])) < 10'(m_q);
      c_wr_en_d = row_ok;
      c_index_d = ADDR_BITS'(nt_d) * ADDR_BITS'(m_q)
                + ADDR_BITS'({mt_d, 2'b00}) + ADDR_BITS'(cnt_d[1:0]);
      for (int unsigned c = 0; c < 4; c++) begin
        c_data_d[(3-c)*ACC_BITS +: ACC_BITS] =
          sa_result[(32'(cnt_d[1:0])*4 + c)*ACC_BITS +: ACC_BITS];
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      sa_rst     <= 1'b0;
      feed_valid <= 1'b0;
      C_wr_en    <= 1'b0;
      A_index    <= '0;
      B_index    <= '0;
      C_index    <= '0;
      C_data_in  <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      k_q        <= k_d;
      n_q        <= n_d;
      mt_q       <= mt_d;
      nt_q       <= nt_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      sa_rst     <= sa_rst_d;
      feed_valid <= feed_valid_d;
      C_wr_en    <= c_wr_en_d;
      A_index    <= a_index_d;
      B_index    <= b_index_d;
      C_index    <= c_index_d;
      C_data_in  <= c_data_d;
    end
  end

endmodule
